mem_port_arbiter: RTL

//  Parametrised successor to the fixed imem/dmem split: arbitrates NUM_CH requesters onto one

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_port_arbiter_rr.sv | 35 +++
 rtl/mem_port_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: channel-id width helper and request op encoding.
package mem_arb_pkg;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    // Width of an encoded channel id; never narrower than one bit.
    function automatic int ch_id_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Round-robin arbiter: the first request found searching upward from ptr (wrapping) wins.
module rr_arbiter #(
    parameter int NUM_CH = 2,
    parameter int ID_W   = 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [ID_W-1:0]   ptr,
    output logic [NUM_CH-1:0] gnt,
    output logic [ID_W-1:0]   id,
    output logic              any
);

    logic [2*NUM_CH-1:0] req2;
    logic [NUM_CH-1:0]   rot;
    logic [ID_W:0]       sum;

    // Rotate so that the pointer channel sits at bit 0; lowest set bit is the winner.
    assign req2 = {req, req};
    assign rot  = NUM_CH'(req2 >> ptr);

    always_comb begin
        sum = '0;
        any = 1'b0;
        for (int f = NUM_CH - 1; f >= 0; f--) begin
            if (rot[f]) begin
                sum = {1'b0, ptr} + (ID_W + 1)'(f);
                any = 1'b1;
            end
        end
        if (sum >= (ID_W + 1)'(NUM_CH)) sum = sum - (ID_W + 1)'(NUM_CH);
        id  = sum[ID_W-1:0];
        gnt = any ? (NUM_CH'(1) << id) : '0;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter of NUM_CH requesters onto one single-port synchronous RAM with pipelined reads.
// Optional per-channel grant counters are built when MEM_ARB_STATS_EN is defined.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH-1:0]        ch_we,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
    output logic [NUM_CH-1:0]        ch_gnt,
    output logic [NUM_CH-1:0]        ch_rvalid,
    output logic [DATA_W-1:0]        ch_rdata,
    output logic [ADDR_W-1:0]        mem_address,
    output logic [DATA_W-1:0]        mem_data,
    output logic                     mem_wren,
    input  logic [DATA_W-1:0]        mem_q,
    output logic [NUM_CH*CNT_W-1:0]  grant_cnt
);

    localparam int ID_W = ch_id_w(NUM_CH);

    typedef struct packed {
        op_e               op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    req_t [NUM_CH-1:0] req_a;
    req_t              sel;
    logic [NUM_CH-1:0] req_m;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   gnt_id;
    logic              gnt_any;
    logic              rd_push;

    logic [MEM_LAT:1]           vld_pipe;
    logic [MEM_LAT:1][ID_W-1:0] id_pipe;

    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : g_req
            assign req_a[i] = {op_e'(ch_we[i]), ch_addr[i*ADDR_W +: ADDR_W], ch_wdata[i*DATA_W +: DATA_W]};
        end
    endgenerate

    // Requests are masked during reset so nothing reaches the RAM or the pointer.
    assign req_m = ch_req & {NUM_CH{~reset}};

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .ID_W   (ID_W)
    ) u_arb (
        .req (req_m),
        .ptr (ptr),
        .gnt (ch_gnt),
        .id  (gnt_id),
        .any (gnt_any)
    );

    assign sel         = gnt_any ? req_a[gnt_id] : '0;
    assign mem_address = sel.addr;
    assign mem_data    = sel.wdata;
    assign mem_wren    = gnt_any && (sel.op == OP_WRITE);
    assign rd_push     = gnt_any && (sel.op == OP_READ);

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= (gnt_id == ID_W'(NUM_CH - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

    // Read tags travel alongside the RAM latency; stage MEM_LAT lines up with mem_q.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            for (int s = MEM_LAT; s > 1; s--) begin
                vld_pipe[s] <= vld_pipe[s-1];
                id_pipe[s]  <= id_pipe[s-1];
            end
            vld_pipe[1] <= rd_push;
            id_pipe[1]  <= gnt_id;
        end
    end

    assign ch_rvalid = (vld_pipe[MEM_LAT] && !reset) ? (NUM_CH'(1) << id_pipe[MEM_LAT]) : '0;
    assign ch_rdata  = (|ch_rvalid) ? mem_q : '0;

`ifdef MEM_ARB_STATS_EN
    logic [NUM_CH-1:0][CNT_W-1:0] cnt;

    always_ff @(posedge clock) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (reset) begin
                cnt[c] <= '0;
            end else if (ch_gnt[c] && (cnt[c] != '1)) begin
                cnt[c] <= cnt[c] + 1'b1;
            end
        end
    end

    assign grant_cnt = cnt;
`else
    assign grant_cnt = '0;
`endif

endmodule
